// File: rtl/maxnet_array.sv
// maxnet_array: N-channel winner-take-all network, one lateral-inhibition iteration per clock
module maxnet_array #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int F = 8,
  parameter int MAX_ITER = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N*W-1:0]                   x_flat,
  input  logic [W-1:0]                     w_self,
  input  logic [W-1:0]                     w_inh,
  output logic                             busy,
  output logic                             done,
  output logic [W-1:0]                     max,
  output logic [$clog2(N)-1:0]             max_idx,
  output logic [$clog2(MAX_ITER+1)-1:0]    iter_cnt,
  output logic                             tie,
  output logic                             timeout,
  output logic                             all_zero
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam int AW = 2 * W + IW + 2;
  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] r [N];
  logic [W-1:0] nxt [N];
  logic signed [AW-1:0] ws, wi, total, rv, acc, sh;
  logic [IW:0] nz;
  logic [W-1:0] bv;
  logic [IW-1:0] bi;
  logic nxt_zero, fin, upd, at_lim;
  assign ws = {{(AW-W){w_self[W-1]}}, w_self};
  assign wi = {{(AW-W){w_inh[W-1]}}, w_inh};
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign at_lim = iter_cnt == CW'(MAX_ITER);
  // next vector, nonzero count and winner (largest value, lowest index) from current registers
  always_comb begin
    total = '0;
    for (int i = 0; i < N; i++) total = total + {{(AW-W){1'b0}}, r[i]};
    nz = '0;
    bv = r[0];
    bi = '0;
    nxt_zero = 1'b1;
    rv = '0;
    acc = '0;
    sh = '0;
    for (int i = 0; i < N; i++) begin
      rv = {{(AW-W){1'b0}}, r[i]};
      acc = ws * rv + wi * (total - rv);
      sh = acc >>> F;
      nxt[i] = (sh[AW-1] || sh == '0) ? '0 : sh > MAXV ? MAXV[W-1:0] : sh[W-1:0];
      nxt_zero = nxt_zero && nxt[i] == '0;
      nz = nz + (IW+1)'(r[i] != '0);
      if (r[i] > bv) begin
        bv = r[i];
        bi = IW'(i);
      end
    end
  end
  // run termination check and next state
  always_comb begin
    fin = state == ITER && (nz < (IW+1)'(2) || at_lim || nxt_zero);
    upd = state == ITER && !fin;
    state_nx = state == IDLE ? (start ? ITER : IDLE) : state == DONE ? IDLE : fin ? DONE : ITER;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // channel registers, iteration counter and held results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '{default: '0};
      iter_cnt <= '0;
      max <= '0;
      max_idx <= '0;
      tie <= 1'b0;
      timeout <= 1'b0;
      all_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        for (int i = 0; i < N; i++) r[i] <= x_flat[i*W+W-1] ? '0 : x_flat[i*W +: W];
        iter_cnt <= '0;
        tie <= 1'b0;
        timeout <= 1'b0;
        all_zero <= 1'b0;
      end
      if (upd) begin
        r <= nxt;
        iter_cnt <= iter_cnt + CW'(1);
      end
      if (fin) begin
        max <= bv;
        max_idx <= bi;
        all_zero <= nz == '0;
        timeout <= nz >= (IW+1)'(2) && at_lim;
        tie <= nz >= (IW+1)'(2) && !at_lim && nxt_zero;
      end
    end
  end
endmodule

// File: tb/tb_maxnet_array.sv
// tb_maxnet_array: table vectors, corner sequences and randomized runs against a reference model
module tb_maxnet_array;
  typedef struct {
    logic [15:0] mx;
    logic [1:0]  idx;
    int          it;
    logic        tie;
    logic        to;
    logic        az;
    int          lat;
  } res_t;
  typedef struct {
    logic [63:0] x;
    logic [15:0] ws;
    logic [15:0] wi;
    res_t        e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [63:0] x_flat = '0;
  logic [15:0] w_self = '0;
  logic [15:0] w_inh = '0;
  logic busy, done, tie, timeout, all_zero;
  logic [15:0] mx;
  logic [1:0] mi;
  logic [6:0] ic;
  logic busy2, done2, tie2, to2, az2;
  logic [15:0] mx2;
  logic [1:0] mi2;
  logic [1:0] ic2;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  maxnet_array #(.N(4), .W(16), .F(8), .MAX_ITER(64)) dut (
    .clk(clk), .rst(rst), .start(start), .x_flat(x_flat), .w_self(w_self), .w_inh(w_inh),
    .busy(busy), .done(done), .max(mx), .max_idx(mi), .iter_cnt(ic),
    .tie(tie), .timeout(timeout), .all_zero(all_zero));
  maxnet_array #(.N(4), .W(16), .F(8), .MAX_ITER(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_flat(x_flat), .w_self(w_self), .w_inh(w_inh),
    .busy(busy2), .done(done2), .max(mx2), .max_idx(mi2), .iter_cnt(ic2),
    .tie(tie2), .timeout(to2), .all_zero(az2));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // iterate the network rules directly on integer values until a stop condition
  function automatic res_t model(input logic [63:0] xv, input logic [15:0] s, input logic [15:0] h, input int lim);
    res_t r;
    longint v[4], nv[4];
    longint tot, a, sw, hw;
    int nz, it, b;
    bit zero;
    r = '{mx: '0, idx: '0, it: 0, tie: 1'b0, to: 1'b0, az: 1'b0, lat: 0};
    sw = longint'(signed'(s));
    hw = longint'(signed'(h));
    for (int i = 0; i < 4; i++) v[i] = xv[i*16+15] ? 0 : longint'(xv[i*16 +: 16]);
    it = 0;
    for (int g = 0; g < 1000; g++) begin
      nz = 0;
      b = 0;
      for (int i = 0; i < 4; i++) begin
        if (v[i] != 0) nz++;
        if (v[i] > v[b]) b = i;
      end
      r.mx = 16'(v[b]);
      r.idx = 2'(b);
      r.it = it;
      r.lat = it + 2;
      if (nz == 0) begin r.az = 1'b1; break; end
      if (nz == 1) break;
      if (it == lim) begin r.to = 1'b1; break; end
      tot = 0;
      for (int i = 0; i < 4; i++) tot += v[i];
      zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
        a = (sw * v[i] + hw * (tot - v[i])) >>> 8;
        nv[i] = a <= 0 ? 0 : a > 32767 ? 32767 : a;
        if (nv[i] != 0) zero = 1'b0;
      end
      if (zero) begin r.tie = 1'b1; break; end
      v = nv;
      it++;
    end
    return r;
  endfunction
  task automatic run(input logic [63:0] xv, input logic [15:0] s, input logic [15:0] h, output int lat);
    @(negedge clk);
    x_flat = xv;
    w_self = s;
    w_inh = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", busy, 1'b1);
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic check_res(input string nm, input res_t e, input int lat);
    chk({nm, ".lat"}, lat, e.lat);
    chk({nm, ".max"}, mx, e.mx);
    chk({nm, ".max_idx"}, mi, e.idx);
    chk({nm, ".iter_cnt"}, ic, e.it);
    chk({nm, ".tie"}, tie, e.tie);
    chk({nm, ".timeout"}, timeout, e.to);
    chk({nm, ".all_zero"}, all_zero, e.az);
    @(negedge clk);
    chk({nm, ".done_pulse"}, done, 1'b0);
    chk({nm, ".busy_end"}, busy, 1'b0);
  endtask
  initial begin
    vec_t tbl[5];
    res_t e;
    int lat;
    logic [7:0] mask;
    logic [63:0] xv;
    logic [15:0] s, h;
    tbl[0] = '{64'h0100_00C0_0040_0080, 16'h0100, 16'hFFC0, '{16'h0080, 2'd3, 4, 1'b0, 1'b0, 1'b0, 6}};
    tbl[1] = '{64'hFFFF_0200_0000_FF00, 16'h0100, 16'hFFC0, '{16'h0200, 2'd2, 0, 1'b0, 1'b0, 1'b0, 2}};
    tbl[2] = '{64'h8000_FFFF_0000_FF80, 16'h0100, 16'hFFC0, '{16'h0000, 2'd0, 0, 1'b0, 1'b0, 1'b1, 2}};
    tbl[3] = '{64'h0000_0100_0100_0000, 16'h0100, 16'hFFC0, '{16'h0001, 2'd1, 16, 1'b1, 1'b0, 1'b0, 18}};
    tbl[4] = '{64'h0010_0000_0000_7000, 16'h0200, 16'hFFC0, '{16'h7FFF, 2'd0, 1, 1'b0, 1'b0, 1'b0, 3}};
    #12;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.max", mx, 16'h0);
    chk("reset.iter_cnt", ic, 7'h0);
    chk("reset.flags", {tie, timeout, all_zero}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].x, tbl[i].ws, tbl[i].wi, lat);
      check_res($sformatf("vec%0d", i), tbl[i].e, lat);
    end
    @(negedge clk);
    x_flat = tbl[0].x;
    w_self = tbl[0].ws;
    w_inh = tbl[0].wi;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo.lat", lat, 4);
    chk("tmo.timeout", to2, 1'b1);
    chk("tmo.iter_cnt", ic2, 2'd2);
    chk("tmo.max", mx2, 16'h008C);
    chk("tmo.max_idx", mi2, 2'd3);
    chk("tmo.tie_zero", {tie2, az2}, 2'b00);
    @(negedge clk);
    x_flat = tbl[1].x;
    w_self = tbl[1].ws;
    w_inh = tbl[1].wi;
    start = 1'b1;
    mask = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mask[c] = done;
    end
    start = 1'b0;
    chk("b2b.done_mask", mask, 8'b0010_0100);
    repeat (3) @(negedge clk);
    chk("b2b.idle", busy, 1'b0);
    run(tbl[0].x, tbl[0].ws, tbl[0].wi, lat);
    check_res("pre_rst", tbl[0].e, lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.done", done, 1'b0);
    chk("midrst.max", mx, 16'h0);
    chk("midrst.max_idx", mi, 2'd0);
    chk("midrst.iter_cnt", ic, 7'h0);
    chk("midrst.flags", {tie, timeout, all_zero}, 3'b000);
    mask = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mask[c] = done | busy;
    end
    rst = 1'b1;
    for (int c = 3; c < 6; c++) begin
      @(negedge clk);
      mask[c] = done | busy;
    end
    chk("midrst.quiet", mask, 8'h00);
    run(tbl[0].x, tbl[0].ws, tbl[0].wi, lat);
    check_res("post_rst", tbl[0].e, lat);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        xv[i*16 +: 16] = $urandom_range(0, 3) == 0 ? (16'($urandom) | 16'h8000) : 16'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) == 0) xv[47:32] = xv[15:0];
      s = 16'($urandom_range(128, 320));
      h = 16'(-int'($urandom_range(8, 128)));
      e = model(xv, s, h, 64);
      run(xv, s, h, lat);
      check_res($sformatf("rnd%0d", n), e, lat);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
